// File: rtl/onehot_decoder_fifo.sv
// Buffered 2-to-4 decoder: {v, code} entries go through a DEPTH-entry FIFO and are delivered one-hot.
// Optional per-line delivery counters are built when ONEHOT_DEC_HIT_CNT_EN is defined.
module onehot_decoder_fifo #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [1:0]               in_code,
    input  logic                     in_v,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [3:0]               out_d,
    output logic                     out_none,
    output logic [$clog2(DEPTH):0]   level,
    input  logic                     clr_cnt,
    output logic [4*CNT_W-1:0]       hit_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

    logic [2:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   level_q, level_d;
    logic          push, pop;
    logic [2:0]    head;

    // Handshakes depend only on registered occupancy, never on the peer's valid/ready.
    assign in_ready  = (level_q != FULL_LVL);
    assign out_valid = (level_q != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign head      = mem_q[rd_ptr_q];
    assign level     = level_q;

    always_comb begin
        out_d    = 4'b0000;
        out_none = 1'b0;
        if (out_valid) begin
            out_d    = head[2] ? (4'b0001 << head[1:0]) : 4'b0000;
            out_none = !head[2];
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage has no reset; a write during reset lands in a slot that is then considered empty.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {in_v, in_code};
    end

`ifdef ONEHOT_DEC_HIT_CNT_EN
    logic [CNT_W-1:0] cnt_q [4];

    for (genvar k = 0; k < 4; k++) begin : g_cnt
        always_ff @(posedge clk) begin
            if (!rst_n || clr_cnt) begin
                cnt_q[k] <= '0;
            end else if (pop && head[2] && (head[1:0] == 2'(k)) && (cnt_q[k] != '1)) begin
                cnt_q[k] <= cnt_q[k] + 1'b1;
            end
        end
        assign hit_cnt[k*CNT_W +: CNT_W] = cnt_q[k];
    end
`else
    logic unused_clr;
    assign unused_clr = clr_cnt;
    assign hit_cnt    = '0;
`endif

endmodule

// File: tb/tb_onehot_decoder_fifo.sv
// Randomized + directed bench for onehot_decoder_fifo; a queue-based model tracks the expected contents.
module tb_onehot_decoder_fifo;
    localparam int DEPTH = 4;
    localparam int CNT_W = 8;
    localparam int LW    = $clog2(DEPTH) + 1;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid, in_ready, in_v, out_valid, out_ready, out_none, clr_cnt;
    logic [1:0]       in_code;
    logic [3:0]       out_d;
    logic [LW-1:0]    level;
    logic [4*CNT_W-1:0] hit_cnt;

    onehot_decoder_fifo #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_code(in_code), .in_v(in_v), .out_valid(out_valid), .out_ready(out_ready),
        .out_d(out_d), .out_none(out_none), .level(level), .clr_cnt(clr_cnt),
        .hit_cnt(hit_cnt)
    );

    always #5 clk = ~clk;

    int         vectors = 0;
    int         errors  = 0;
    bit         started = 0;
    logic [2:0] model_q [$];
    int         cnt_m [4];

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: advance on each edge from the inputs that were applied during the cycle.
    always @(posedge clk) begin
        logic [2:0] h;
        bit do_pop, do_push;
        if (!rst_n) begin
            model_q.delete();
            for (int k = 0; k < 4; k++) cnt_m[k] = 0;
        end else begin
            do_pop  = (model_q.size() > 0) && out_ready;
            do_push = in_valid && (model_q.size() < DEPTH);
            h = 3'b000;
            if (do_pop) h = model_q.pop_front();
            if (clr_cnt) begin
                for (int k = 0; k < 4; k++) cnt_m[k] = 0;
            end else if (do_pop && h[2] && cnt_m[h[1:0]] < CMAX) begin
                cnt_m[h[1:0]]++;
            end
            if (do_push) model_q.push_back({in_v, in_code});
        end
        started = 1;
    end

    // Monitor: compare every DUT output against the model head away from the active edge.
    always @(negedge clk) begin
        int exp_d, exp_none, exp_cnt;
        if (started) begin
            exp_d = 0;
            exp_none = 0;
            if (model_q.size() > 0) begin
                exp_d    = model_q[0][2] ? (1 << model_q[0][1:0]) : 0;
                exp_none = model_q[0][2] ? 0 : 1;
            end
            chk("level",     int'(level),     model_q.size());
            chk("out_valid", int'(out_valid), (model_q.size() > 0) ? 1 : 0);
            chk("in_ready",  int'(in_ready),  (model_q.size() < DEPTH) ? 1 : 0);
            chk("out_d",     int'(out_d),     exp_d);
            chk("out_none",  int'(out_none),  exp_none);
            for (int k = 0; k < 4; k++) begin
`ifdef ONEHOT_DEC_HIT_CNT_EN
                exp_cnt = cnt_m[k];
`else
                exp_cnt = 0;
`endif
                chk($sformatf("hit_cnt[%0d]", k), int'(hit_cnt[k*CNT_W +: CNT_W]), exp_cnt);
            end
        end
    end

    task automatic step(input bit vld, input bit v, input int code, input bit rdy, input bit clr);
        in_valid  = vld;
        in_v      = v;
        in_code   = 2'(code);
        out_ready = rdy;
        clr_cnt   = clr;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        rst_n = 1'b1;

        // Single entry with ready downstream, then drain.
        step(1, 1, 2, 1, 0);
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 1, 0);

        // Fill to full with the four codes, attempt a fifth push, drain in order.
        for (int c = 0; c < 4; c++) step(1, 1, c, 0, 0);
        step(1, 1, 0, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 1, 0);

        // Entry with v=0 decodes to none and is not counted.
        step(1, 0, 3, 0, 0);
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 1, 0);

        // Full with push and pop offered together: only the pop happens, then a push fits.
        for (int c = 0; c < 4; c++) step(1, 1, c, 0, 0);
        step(1, 1, 1, 1, 0);
        step(1, 1, 2, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 1, 0);

        // Sustained push+pop at level 1, exercising pointer wrap.
        step(1, 1, 0, 0, 0);
        for (int i = 0; i < 20; i++) step(1, $urandom_range(0, 1), $urandom_range(0, 3), 1, 0);
        for (int i = 0; i < 2; i++) step(0, 0, 0, 1, 0);

        // Saturate line 1, then clear coinciding with a pop of code 1.
        for (int i = 0; i < 262; i++) step(1, 1, 1, 1, 0);
        step(0, 0, 0, 1, 1);
        step(0, 0, 0, 1, 0);

        // Reset mid-stream with level 3 and both handshakes offered.
        for (int c = 0; c < 3; c++) step(1, 1, c, 0, 0);
        rst_n = 1'b0;
        step(1, 1, 3, 1, 0);
        rst_n = 1'b1;
        step(0, 0, 0, 1, 0);

        // Randomized traffic with varying pressure on each side.
        for (int i = 0; i < 2000; i++) begin
            int pv, pr;
            pv = (i < 1000) ? 70 : 30;
            pr = (i < 1000) ? 30 : 70;
            if ($urandom_range(0, 299) == 0) rst_n = 1'b0;
            step($urandom_range(0, 99) < pv, $urandom_range(0, 3) != 0, $urandom_range(0, 3),
                 $urandom_range(0, 99) < pr, $urandom_range(0, 199) == 0);
            rst_n = 1'b1;
        end
        step(0, 0, 0, 1, 0);
        @(negedge clk);
        #1;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
